// File: rtl/mac_frame_sequencer.sv
// Time-multiplexed multiply-accumulate sequencer: one DATA_W x DATA_W multiplier
// and a wrapping accumulator swept over a frame of N_TERMS operand pairs.
module mac_frame_sequencer #(
   parameter int DATA_W  = 4,
   parameter int ACC_W   = 8,
   parameter int N_TERMS = 128,
   parameter int CNT_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic              busy,
   output logic [CNT_W-1:0]  term_cnt
);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(N_TERMS - 1);

   state_t             state;
   logic [ACC_W-1:0]   acc;
   logic [ACC_W-1:0]   acc_next;

   // Product is formed at full 2*DATA_W width, then resized to the accumulator;
   // the sum wraps modulo 2^ACC_W.
   function automatic logic [ACC_W-1:0] wrap_mac(input logic [ACC_W-1:0]  sum,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
      logic [2*DATA_W-1:0] prod;
      prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
      return sum + ACC_W'(prod);
   endfunction

   assign acc_next = wrap_mac(acc, in_a, in_b);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         term_cnt  <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= ACCUM;
                  acc      <= '0;
                  term_cnt <= '0;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            ACCUM: begin
               if (in_valid && in_ready) begin
                  acc      <= acc_next;
                  term_cnt <= term_cnt + CNT_W'(1);
                  // Final pair: publish the sum directly so out_valid rises next cycle.
                  if (term_cnt == LAST_TERM) begin
                     state     <= DONE;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                     out_sum   <= acc_next;
                  end
               end
            end
            DONE: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  if (start) begin
                     state    <= ACCUM;
                     acc      <= '0;
                     term_cnt <= '0;
                     in_ready <= 1'b1;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mac_frame_sequencer.sv
// Directed bench for mac_frame_sequencer: default 128-term build plus a
// single-term build driven from the same clock and reset.
module tb_mac_frame_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [3:0] in_a = '0, in_b = '0;
   logic       in_ready, out_valid, busy;
   logic [7:0] out_sum, term_cnt;

   logic       start1 = 1'b0, in_valid1 = 1'b0, out_ready1 = 1'b0;
   logic [3:0] in_a1 = '0, in_b1 = '0;
   logic       in_ready1, out_valid1, busy1;
   logic [7:0] out_sum1;
   logic [1:0] term_cnt1;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mac_frame_sequencer #(.DATA_W(4), .ACC_W(8), .N_TERMS(128), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .busy(busy), .term_cnt(term_cnt)
   );

   mac_frame_sequencer #(.DATA_W(4), .ACC_W(8), .N_TERMS(1), .CNT_W(2)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid1), .in_ready(in_ready1),
      .in_a(in_a1), .in_b(in_b1), .out_valid(out_valid1), .out_ready(out_ready1),
      .out_sum(out_sum1), .busy(busy1), .term_cnt(term_cnt1)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Drives n identical pairs, each held until accepted (bounded wait).
   task automatic drive_pairs(input int n, input logic [3:0] a, input logic [3:0] b);
      for (int k = 0; k < n; k++) begin
         int guard;
         in_valid = 1'b1;
         in_a     = a;
         in_b     = b;
         guard    = 0;
         while (!in_ready && guard < 8) begin
            tick();
            guard++;
         end
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic start_frame;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset;
      #2;
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (out_sum !== 8'h00) begin n_err++; $display("FAIL rst_out_sum: got %h want 00", out_sum); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_cmp++; if (term_cnt !== 8'd0) begin n_err++; $display("FAIL rst_term_cnt: got %0d want 0", term_cnt); end
      tick();
      rst = 1'b0;
      tick();
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_full_frame;
      int cycles;
      start_frame();
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL t1_in_ready: got %b want 1", in_ready); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL t1_busy: got %b want 1", busy); end
      in_valid = 1'b1; in_a = 4'd15; in_b = 4'd15;
      cycles = 0;
      while (!out_valid && cycles < 300) begin
         tick();
         cycles++;
      end
      in_valid = 1'b0;
      // 128 transfer edges after the edge that sampled start.
      n_cmp++; if (cycles !== 128) begin n_err++; $display("FAIL t1_latency: got %0d edges want 128", cycles); end
      n_cmp++; if (out_sum !== 8'h80) begin n_err++; $display("FAIL t1_sum: got %h want 80", out_sum); end
      n_cmp++; if (term_cnt !== 8'd128) begin n_err++; $display("FAIL t1_term_cnt: got %0d want 128", term_cnt); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL t1_done_in_ready: got %b want 0", in_ready); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL t1_valid_drop: got %b want 0", out_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL t1_idle_busy: got %b want 0", busy); end
      n_cmp++; if (term_cnt !== 8'd128) begin n_err++; $display("FAIL t1_idle_cnt: got %0d want 128", term_cnt); end
      n_cmp++; if (out_sum !== 8'h80) begin n_err++; $display("FAIL t1_idle_sum: got %h want 80", out_sum); end
   endtask

   task automatic test_gaps;
      int i, cyc;
      logic xfer;
      start_frame();
      i = 0;
      cyc = 0;
      while (i < 128 && cyc < 1000) begin
         in_valid = (cyc % 3 != 2);
         in_a     = 4'(i % 16);
         in_b     = 4'd1;
         xfer     = in_valid && in_ready;
         tick();
         if (xfer) i++;
         cyc++;
         n_cmp++; if (term_cnt !== 8'(i)) begin n_err++; $display("FAIL t2_term_cnt: got %0d want %0d", term_cnt, i); end
      end
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL t2_valid: got %b want 1", out_valid); end
      n_cmp++; if (out_sum !== 8'hC0) begin n_err++; $display("FAIL t2_sum: got %h want c0", out_sum); end
   endtask

   task automatic test_hold;
      out_ready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         in_valid = 1'b1; in_a = 4'd7; in_b = 4'd9;
         tick();
         n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL t3_valid: got %b want 1", out_valid); end
         n_cmp++; if (out_sum !== 8'hC0) begin n_err++; $display("FAIL t3_sum: got %h want c0", out_sum); end
         n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL t3_in_ready: got %b want 0", in_ready); end
         n_cmp++; if (term_cnt !== 8'd128) begin n_err++; $display("FAIL t3_term_cnt: got %0d want 128", term_cnt); end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL t3_release: got %b want 0", out_valid); end
   endtask

   task automatic test_start_ignored;
      start_frame();
      drive_pairs(40, 4'd1, 4'd1);
      start = 1'b1;
      tick();
      start = 1'b0;
      n_cmp++; if (term_cnt !== 8'd40) begin n_err++; $display("FAIL t4_cnt_after_start: got %0d want 40", term_cnt); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL t4_in_ready: got %b want 1", in_ready); end
      drive_pairs(88, 4'd2, 4'd1);
      // 40*1 + 88*2 = 216
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL t4_valid: got %b want 1", out_valid); end
      n_cmp++; if (out_sum !== 8'hD8) begin n_err++; $display("FAIL t4_sum: got %h want d8", out_sum); end
   endtask

   task automatic test_back_to_back;
      start = 1'b1; out_ready = 1'b1;
      tick();
      start = 1'b0; out_ready = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_valid: got %b want 0", out_valid); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy: got %b want 1", busy); end
      n_cmp++; if (term_cnt !== 8'd0) begin n_err++; $display("FAIL b2b_term_cnt: got %0d want 0", term_cnt); end
      drive_pairs(128, 4'd1, 4'd1);
      n_cmp++; if (out_sum !== 8'h80) begin n_err++; $display("FAIL b2b_sum: got %h want 80", out_sum); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got %b want 0", busy); end
   endtask

   task automatic test_async_reset;
      start_frame();
      drive_pairs(60, 4'd1, 4'd1);
      n_cmp++; if (term_cnt !== 8'd60) begin n_err++; $display("FAIL t5_pre_cnt: got %0d want 60", term_cnt); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL t5_in_ready: got %b want 0", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL t5_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (out_sum !== 8'h00) begin n_err++; $display("FAIL t5_out_sum: got %h want 00", out_sum); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL t5_busy: got %b want 0", busy); end
      n_cmp++; if (term_cnt !== 8'd0) begin n_err++; $display("FAIL t5_term_cnt: got %0d want 0", term_cnt); end
      tick();
      rst = 1'b0;
      tick();
      start_frame();
      drive_pairs(128, 4'd1, 4'd1);
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL t5_valid: got %b want 1", out_valid); end
      n_cmp++; if (out_sum !== 8'h80) begin n_err++; $display("FAIL t5_sum: got %h want 80", out_sum); end
      n_cmp++; if (term_cnt !== 8'd128) begin n_err++; $display("FAIL t5_term_cnt_end: got %0d want 128", term_cnt); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_single_term;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      n_cmp++; if (in_ready1 !== 1'b1) begin n_err++; $display("FAIL t6_in_ready: got %b want 1", in_ready1); end
      in_valid1 = 1'b1; in_a1 = 4'd15; in_b1 = 4'd15;
      tick();
      in_valid1 = 1'b0;
      n_cmp++; if (out_valid1 !== 1'b1) begin n_err++; $display("FAIL t6_valid: got %b want 1", out_valid1); end
      n_cmp++; if (out_sum1 !== 8'hE1) begin n_err++; $display("FAIL t6_sum: got %h want e1", out_sum1); end
      n_cmp++; if (term_cnt1 !== 2'd1) begin n_err++; $display("FAIL t6_term_cnt: got %0d want 1", term_cnt1); end
      out_ready1 = 1'b1;
      tick();
      out_ready1 = 1'b0;
      n_cmp++; if (out_valid1 !== 1'b0) begin n_err++; $display("FAIL t6_release: got %b want 0", out_valid1); end
      n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL t6_idle: got %b want 0", busy1); end
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_gaps();
      test_hold();
      test_start_ignored();
      test_back_to_back();
      test_async_reset();
      test_single_term();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
